// File: rtl/mmio_bridge_pkg.sv
// Shared constants for the MMIO bridge: I/O register offsets and the processor data width.
package mmio_bridge_pkg;
    localparam int DATA_W = 32;

    localparam logic [3:0] OFF_LED   = 4'd0;
    localparam logic [3:0] OFF_SW    = 4'd1;
    localparam logic [3:0] OFF_EDGE  = 4'd2;
    localparam logic [3:0] OFF_TIMER = 4'd3;
endpackage

// File: rtl/sw_debounce.sv
// Switch conditioner: 2-flop synchronizer per bit and one shared debounce counter.
// stable loads all synced bits at once; rise pulses on the cycle stable takes a 0->1 bit.
module sw_debounce #(
    parameter int SW_W            = 5,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [SW_W-1:0] sw_async,
    output logic [SW_W-1:0] stable,
    output logic [SW_W-1:0] rise
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SW_W-1:0]  sync1_q, sync1_d;
    logic [SW_W-1:0]  sync2_q, sync2_d;
    logic [SW_W-1:0]  stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d  = sw_async;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        rise     = '0;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            stable_d = sync2_q;
            cnt_d    = '0;
            rise     = sync2_q & ~stable_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;
endmodule

// File: rtl/mmio_bridge.sv
// Processor data-port bridge: splits accesses between dmem RAM and a 16-word I/O window
// (LED, debounced switches, sticky switch edges, optional free-running TIMER under MMIO_TIMER_EN).
module mmio_bridge
    import mmio_bridge_pkg::*;
#(
    parameter int                ADDR_W          = 12,
    parameter int                LED_W           = 16,
    parameter int                SW_W            = 5,
    parameter int                DEBOUNCE_CYCLES = 1000,
    parameter logic [ADDR_W-1:0] IO_BASE         = 12'hF00
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wren,
    input  logic [31:0]       address_dmem,
    input  logic [31:0]       data,
    output logic [31:0]       q_dmem,
    output logic              ram_wEn,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_dataIn,
    input  logic [31:0]       ram_dataOut,
    input  logic [SW_W-1:0]   SW,
    output logic [LED_W-1:0]  LED
);
    logic              hit, wr_io;
    logic [3:0]        offset;
    logic [SW_W-1:0]   sw_stable, sw_rise;
    logic              unused_addr_hi;

    logic              hit_q, hit_d;
    logic [DATA_W-1:0] io_rdata_q, io_rdata_d;
    logic [LED_W-1:0]  led_q, led_d;
    logic [SW_W-1:0]   sw_edge_q, sw_edge_d;

    assign hit            = (address_dmem[ADDR_W-1:4] == IO_BASE[ADDR_W-1:4]);
    assign offset         = address_dmem[3:0];
    assign wr_io          = wren & hit;
    assign unused_addr_hi = ^address_dmem[31:ADDR_W];

    assign ram_addr   = address_dmem[ADDR_W-1:0];
    assign ram_dataIn = data;
    assign ram_wEn    = wren & ~hit;

    sw_debounce #(
        .SW_W            (SW_W),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sw_debounce (
        .clock    (clock),
        .reset    (reset),
        .sw_async (SW),
        .stable   (sw_stable),
        .rise     (sw_rise)
    );

`ifdef MMIO_TIMER_EN
    logic [DATA_W-1:0] timer_q, timer_d;

    always_comb begin
        timer_d = timer_q + 1'b1;
        if (wr_io && offset == OFF_TIMER) timer_d = '0;
    end

    always_ff @(posedge clock) begin
        if (reset) timer_q <= '0;
        else       timer_q <= timer_d;
    end
`endif

    always_comb begin
        led_d = led_q;
        if (wr_io && offset == OFF_LED) led_d = data[LED_W-1:0];

        // A new rising edge is ORed in after the clear so it survives a same-cycle W1C.
        sw_edge_d = sw_edge_q;
        if (wr_io && offset == OFF_EDGE) sw_edge_d = sw_edge_q & ~data[SW_W-1:0];
        sw_edge_d = sw_edge_d | sw_rise;

        hit_d      = hit;
        io_rdata_d = '0;
        case (offset)
            OFF_LED:   io_rdata_d[LED_W-1:0] = led_q;
            OFF_SW:    io_rdata_d[SW_W-1:0]  = sw_stable;
            OFF_EDGE:  io_rdata_d[SW_W-1:0]  = sw_edge_q;
            OFF_TIMER: begin
`ifdef MMIO_TIMER_EN
                io_rdata_d = timer_q;
`else
                io_rdata_d = '0;
`endif
            end
            default:   io_rdata_d = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hit_q      <= 1'b0;
            io_rdata_q <= '0;
            led_q      <= '0;
            sw_edge_q  <= '0;
        end else begin
            hit_q      <= hit_d;
            io_rdata_q <= io_rdata_d;
            led_q      <= led_d;
            sw_edge_q  <= sw_edge_d;
        end
    end

    // RAM data arrives one cycle after the address, so the I/O path is aligned by hit_q.
    assign q_dmem = hit_q ? io_rdata_q : ram_dataOut;
    assign LED    = led_q;
endmodule

// File: tb/tb_mmio_bridge.sv
// Self-checking bench for mmio_bridge: directed vector table, multi-cycle sequences, random ops vs model.
module tb_mmio_bridge;
    localparam int          ADDR_W  = 12;
    localparam int          LED_W   = 16;
    localparam int          SW_W    = 5;
    localparam int          DB      = 4;
    localparam logic [11:0] IO_BASE = 12'hF00;

    logic              clock = 1'b0;
    logic              reset;
    logic              wren;
    logic [31:0]       address_dmem;
    logic [31:0]       data;
    logic [31:0]       q_dmem;
    logic              ram_wEn;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_dataIn;
    logic [31:0]       ram_dataOut;
    logic [SW_W-1:0]   SW;
    logic [LED_W-1:0]  LED;

    mmio_bridge #(
        .ADDR_W(ADDR_W), .LED_W(LED_W), .SW_W(SW_W), .DEBOUNCE_CYCLES(DB), .IO_BASE(IO_BASE)
    ) dut (
        .clock(clock), .reset(reset), .wren(wren), .address_dmem(address_dmem), .data(data),
        .q_dmem(q_dmem), .ram_wEn(ram_wEn), .ram_addr(ram_addr), .ram_dataIn(ram_dataIn),
        .ram_dataOut(ram_dataOut), .SW(SW), .LED(LED)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] pat(input logic [11:0] a);
        return {8'hC3, a, a};
    endfunction

    // Dmem RAM with registered read; unwritten words return pat(addr).
    logic [31:0] mem [0:4095];
    bit          mem_wr [0:4095];
    always @(posedge clock) begin
        if (ram_wEn) begin
            mem[ram_addr]    <= ram_dataIn;
            mem_wr[ram_addr] <= 1'b1;
        end
        ram_dataOut <= mem_wr[ram_addr] ? mem[ram_addr] : pat(ram_addr);
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_wen;
        logic        chk_q;
        logic [31:0] exp_q;
        logic [15:0] exp_led;
    } vec_t;

    localparam int NV = 21;
    vec_t        tbl [NV];
    logic [31:0] ref_mem [0:4095];
    logic [15:0] m_led;
    logic [4:0]  m_edge;
    logic [4:0]  m_stable;

    initial begin
        for (int i = 0; i < 4096; i++) ref_mem[i] = pat(12'(i));

        tbl[0]  = '{1'b1, 32'h0000_0F00, 32'h1234_ABCD, 1'b0, 1'b0, 32'h0,         16'hABCD};
        tbl[1]  = '{1'b0, 32'h0000_0F00, 32'h0,         1'b0, 1'b1, 32'h0000_ABCD, 16'hABCD};
        tbl[2]  = '{1'b1, 32'h0000_0010, 32'h0000_0055, 1'b1, 1'b0, 32'h0,         16'hABCD};
        tbl[3]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 1'b1, 32'h0000_0055, 16'hABCD};
        tbl[4]  = '{1'b1, 32'h0000_0F05, 32'h0000_FFFF, 1'b0, 1'b0, 32'h0,         16'hABCD};
        tbl[5]  = '{1'b0, 32'h0000_0F05, 32'h0,         1'b0, 1'b1, 32'h0,         16'hABCD};
        tbl[6]  = '{1'b0, 32'h0000_0F00, 32'h0,         1'b0, 1'b1, 32'h0000_ABCD, 16'hABCD};
        tbl[7]  = '{1'b1, 32'h0000_0F03, 32'h1234_5678, 1'b0, 1'b0, 32'h0,         16'hABCD};
        tbl[8]  = '{1'b0, 32'h0000_0F03, 32'h0,         1'b0, 1'b1, 32'h0,         16'hABCD};
        tbl[9]  = '{1'b0, 32'h0000_0F01, 32'h0,         1'b0, 1'b1, 32'h0,         16'hABCD};
        tbl[10] = '{1'b0, 32'h0000_0F02, 32'h0,         1'b0, 1'b1, 32'h0,         16'hABCD};
        tbl[11] = '{1'b1, 32'hABCD_EF00, 32'h0000_00FF, 1'b0, 1'b0, 32'h0,         16'h00FF};
        tbl[12] = '{1'b0, 32'h0000_0F00, 32'h0,         1'b0, 1'b1, 32'h0000_00FF, 16'h00FF};
        tbl[13] = '{1'b1, 32'h0000_00F0, 32'h0000_0077, 1'b1, 1'b0, 32'h0,         16'h00FF};
        tbl[14] = '{1'b1, 32'h0000_0FF0, 32'h0000_0088, 1'b1, 1'b0, 32'h0,         16'h00FF};
        tbl[15] = '{1'b0, 32'h0000_00F0, 32'h0,         1'b0, 1'b1, 32'h0000_0077, 16'h00FF};
        tbl[16] = '{1'b0, 32'h0000_0FF0, 32'h0,         1'b0, 1'b1, 32'h0000_0088, 16'h00FF};
        tbl[17] = '{1'b0, 32'h0000_03FC, 32'h0,         1'b0, 1'b1, pat(12'h3FC),  16'h00FF};
        tbl[18] = '{1'b1, 32'h0000_0F0F, 32'h0000_0001, 1'b0, 1'b0, 32'h0,         16'h00FF};
        tbl[19] = '{1'b0, 32'h0000_0F0F, 32'h0,         1'b0, 1'b1, 32'h0,         16'h00FF};
        tbl[20] = '{1'b0, 32'h0000_0F10, 32'h0,         1'b0, 1'b1, pat(12'hF10),  16'h00FF};

        // Reset state
        reset = 1'b1; wren = 1'b0; address_dmem = 32'h100; data = '0; SW = '0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_led", 32'(LED), 32'h0);
        chk("rst_wen", 32'(ram_wEn), 32'h0);
        chk("rst_q_is_ram", q_dmem, ref_mem[12'h100]);

        // Directed vectors
        for (int i = 0; i < NV; i++) begin
            wren = tbl[i].wr; address_dmem = tbl[i].addr; data = tbl[i].wdata;
            #1;
            chk($sformatf("v%0d_wen", i), 32'(ram_wEn), 32'(tbl[i].exp_wen));
            chk($sformatf("v%0d_raddr", i), 32'(ram_addr), 32'(tbl[i].addr[11:0]));
            if (tbl[i].exp_wen) ref_mem[tbl[i].addr[11:0]] = tbl[i].wdata;
            tick();
            if (tbl[i].chk_q) chk($sformatf("v%0d_q", i), q_dmem, tbl[i].exp_q);
            chk($sformatf("v%0d_led", i), 32'(LED), 32'(tbl[i].exp_led));
        end
        wren = 1'b0;

        // Debounce: 2 sync + DB counter cycles, visible on the read one cycle later
        address_dmem = 32'hF01; SW = 5'b00001;
        repeat (6) tick();
        chk("db_early", q_dmem, 32'h0);
        tick();
        chk("db_stable", q_dmem, 32'h1);
        SW = 5'b00000; tick(); tick(); SW = 5'b00001;
        repeat (8) tick();
        chk("db_glitch", q_dmem, 32'h1);

        // Sticky edge and write-1-to-clear
        address_dmem = 32'hF02; tick();
        chk("edge_set", q_dmem, 32'h1);
        wren = 1'b1; data = 32'h1; tick(); wren = 1'b0; tick();
        chk("edge_w1c", q_dmem, 32'h0);
        SW = 5'b00000; repeat (10) tick();
        chk("edge_no_fall", q_dmem, 32'h0);
        SW = 5'b00001; repeat (5) tick();
        wren = 1'b1; data = 32'h1; tick(); wren = 1'b0; tick();
        chk("edge_set_wins", q_dmem, 32'h1);
        wren = 1'b1; data = 32'h1; tick(); wren = 1'b0; tick();
        chk("edge_later_clr", q_dmem, 32'h0);

        // Timer
        address_dmem = 32'hF03;
`ifdef MMIO_TIMER_EN
        wren = 1'b1; data = 32'hDEAD_BEEF; tick(); wren = 1'b0; tick();
        chk("timer_zero", q_dmem, 32'h0);
        tick();
        chk("timer_one", q_dmem, 32'h1);
        force dut.timer_q = 32'hFFFF_FFFF;
        #2;
        release dut.timer_q;
        tick();
        chk("timer_max", q_dmem, 32'hFFFF_FFFF);
        tick();
        chk("timer_wrap", q_dmem, 32'h0);
`else
        wren = 1'b1; data = 32'hDEAD_BEEF; tick(); wren = 1'b0;
        repeat (5) tick();
        chk("timer_absent", q_dmem, 32'h0);
`endif

        // Reset beats a concurrent LED store
        address_dmem = 32'hF00; wren = 1'b1; data = 32'h0000_BEEF; tick();
        chk("led_pre_rst", 32'(LED), 32'h0000_BEEF);
        reset = 1'b1; data = 32'h0000_1111; tick();
        reset = 1'b0; wren = 1'b0; address_dmem = 32'h020;
        chk("rst_led_store", 32'(LED), 32'h0);
        chk("rst_q_ram", q_dmem, ref_mem[12'hF00]);
        tick();
        chk("rst_load", q_dmem, ref_mem[12'h020]);
        repeat (12) tick();

        // Random traffic vs model; SW held at 1 re-debounced after reset, edge bit0 set again
        m_led = '0; m_edge = 5'b00001; m_stable = 5'b00001;
        for (int n = 0; n < 400; n++) begin
            logic        win, wr, exp_wen;
            logic [3:0]  off;
            logic [11:0] a12;
            logic [31:0] u, d, exp_q;
            win = 1'($urandom_range(0, 1));
            if (win) begin
                off = 4'($urandom_range(0, 14));
                if (off >= 4'd3) off = off + 4'd1;
                a12 = {IO_BASE[11:4], off};
            end else begin
                off = '0;
                do a12 = 12'($urandom_range(0, 4095)); while (a12[11:4] == IO_BASE[11:4]);
            end
            u = $urandom; d = $urandom;
            wr = 1'($urandom_range(0, 1));
            exp_wen = wr && !win;
            if (win) begin
                case (off)
                    4'd0:    exp_q = {16'h0, m_led};
                    4'd1:    exp_q = {27'h0, m_stable};
                    4'd2:    exp_q = {27'h0, m_edge};
                    default: exp_q = 32'h0;
                endcase
            end else begin
                exp_q = ref_mem[a12];
            end
            wren = wr; address_dmem = {u[31:12], a12}; data = d;
            #1;
            chk("rnd_wen", 32'(ram_wEn), 32'(exp_wen));
            chk("rnd_raddr", 32'(ram_addr), 32'(a12));
            tick();
            chk("rnd_q", q_dmem, exp_q);
            if (wr && win && off == 4'd0) m_led = d[15:0];
            if (wr && win && off == 4'd2) m_edge = m_edge & ~d[4:0];
            if (exp_wen) ref_mem[a12] = d;
            chk("rnd_led", 32'(LED), 32'(m_led));
        end
        wren = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mmio_bridge.md
MMIO_BRIDGE -- requirements
Module: mmio_bridge

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 12, dmem word-address width; LED_W, default 16, LED count; SW_W, default 5, switch count; DEBOUNCE_CYCLES, default 1000, switch-stable cycles; IO_BASE, default 12'hF00, I/O window base, 16-word aligned.
REQ-002 One clock; reset is synchronous and active-high; ports named clock and reset.
REQ-003 Port list (name direction width meaning), clock and reset first:
- clock  in  1  system clock
- reset  in  1  sync active-high reset
- wren  in  1  processor store strobe
- address_dmem  in  32  processor data address, low ADDR_W bits used
- data  in  32  processor store data
- q_dmem  out  32  load data to processor
- ram_wEn  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_dataIn  out  32  RAM write data
- ram_dataOut  in  32  RAM read data, 1-cycle registered
- SW  in  SW_W  asynchronous switches
- LED  out  LED_W  LED drive

Function
REQ-004 The I/O window SHALL be hit when address_dmem[ADDR_W-1:4] equals IO_BASE[ADDR_W-1:4]; the offset SHALL be address_dmem[3:0].
REQ-005 ram_addr and ram_dataIn SHALL pass through combinationally; ram_wEn SHALL equal wren AND NOT hit.
REQ-006 Register map by offset: 0 LED (RW, low LED_W bits); 1 SW_STABLE (RO, zero-extended); 2 SW_EDGE (sticky rising edges, write-1-to-clear); 3 TIMER (RO count, any write clears); 4-15 read 0, writes ignored.
REQ-007 Read latency SHALL be 1 cycle for both paths: the hit flag and the I/O read data SHALL be registered on the address cycle, and q_dmem SHALL be the registered I/O data when the registered hit is 1, otherwise ram_dataOut.
REQ-008 I/O writes SHALL take effect on the clock edge of the wren cycle; a read in the next cycle SHALL return the new value.
REQ-009 SW SHALL pass through a 2-flop synchronizer per bit before any other use.
REQ-010 The debouncer SHALL use one shared counter. When synced equals stable, the counter clears. Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1 while still differing, stable SHALL load all synced bits and the counter SHALL clear.
REQ-011 A 0-to-1 transition of any stable bit SHALL set the matching SW_EDGE bit; on the same edge as a write-1-clear to that bit, set SHALL win.
REQ-012 TIMER SHALL be 32 bits, increment every cycle, and wrap from 32'hFFFFFFFF to 0; a write SHALL load 0, so the following cycle reads 0 and the cycle after reads 1.
REQ-013 LED SHALL be driven directly from the LED register.

Reset
REQ-014 On reset, the following SHALL be 0: LED register, synchronizer flops, stable, debounce counter, SW_EDGE, TIMER, registered hit flag and registered I/O read data. q_dmem SHALL be ram_dataOut in the cycle after reset.
REQ-015 Reset SHALL take priority over a concurrent wren; reset asserted mid-debounce SHALL discard the partial count.

Configuration
REQ-016 With macro MMIO_TIMER_EN defined, TIMER SHALL be implemented per REQ-012; without it, offset 3 SHALL read 0, writes to it SHALL be ignored, and no timer flops SHALL exist.

Structure
REQ-017 A shared package SHALL hold the offset constants (OFF_LED=0, OFF_SW=1, OFF_EDGE=2, OFF_TIMER=3) and the 32-bit data width constant.
REQ-018 The debouncer (synchronizer, counter, stable register) SHALL be a sub-module named sw_debounce, parametrised by SW_W and DEBOUNCE_CYCLES.

Verification
REQ-019 Store 0x1234ABCD to IO_BASE+0 -> ram_wEn stays 0; LED = 16'hABCD; load of IO_BASE+0 returns 0x0000ABCD one cycle later.
REQ-020 Store 0x55 to address 0x010, then load it -> ram_wEn=1 on the store; q_dmem = ram_dataOut after the load.
REQ-021 DEBOUNCE_CYCLES=4; SW=5'b00001 held -> SW_STABLE reads 1 after 2+4 cycles; a 2-cycle glitch -> no change.
REQ-022 Rising SW bit0 -> SW_EDGE=1; write 1 in the same cycle as a new edge -> stays 1; a later write of 1 -> reads 0.
REQ-023 With MMIO_TIMER_EN: write TIMER -> reads 0, then 1 next cycle; force 32'hFFFFFFFF -> wraps to 0. Without the macro, TIMER reads 0.
REQ-024 Assert reset during a store to the LED register -> LED = 0; the next load from a RAM address returns ram_dataOut.
